rs_enc_x4_sched: RTL
====================

RS_ENC_X4_SCHED -- requirements
Module: rs_enc_x4_sched

Interface
REQ-001 Parameters SHALL be:
- NREQ, default 4, number of requesters (2..8).
- MSG_WORDS, default 60, 32-bit message words per frame.
- SLOT_CYCLES, default 66, minimum cycles between successive encoder frame starts; must exceed MSG_WORDS.

REQ-002 The block SHALL have one clock; reset is synchronous and active-high.

REQ-003 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- sched_en  in  1  permit new grants
- req  in  NREQ  per-requester frame request, level
- din  in  32*NREQ  requester i data on bits [32i+31:32i]
- rd  out  NREQ  one-hot read strobe to the owning requester
- busy  out  1  frame in progress (DATA or FLUSH)
- owner  out  3  index of current or last grantee
- enc_en  out  1  encoder enable
- enc_frame_start  out  1  encoder frame-start pulse
- enc_din  out  32  encoder data

Function
REQ-004 States SHALL be IDLE, DATA and FLUSH; a word counter cnt SHALL run 0..MSG_WORDS-1 in DATA and 0..SLOT_CYCLES-MSG_WORDS-1 in FLUSH.

REQ-005 IDLE SHALL go to DATA when sched_en=1 and req!=0; the grantee is picked round-robin and owner is updated in the same cycle.

REQ-006 Round-robin priority SHALL start at the index after the last grantee, then ascend with wrap; after reset, index 0 has top priority.

REQ-007 In DATA, rd[owner]=1 combinationally and all other rd bits SHALL be 0; the requester presents its word in the same cycle; rd SHALL be all-zero in IDLE and FLUSH.

REQ-008 enc_din SHALL register din[owner] while in DATA, giving one cycle of latency; otherwise enc_din SHALL register 0.

REQ-009 enc_frame_start SHALL be a one-cycle registered pulse, asserted the cycle after DATA cnt=0.

REQ-010 DATA with cnt=MSG_WORDS-1 SHALL go to FLUSH with cnt=0.

REQ-011 In the last FLUSH cycle, sched_en=1 with req!=0 SHALL go directly to DATA with a new grant; otherwise the block SHALL go to IDLE.
- Back-to-back frame starts are therefore exactly SLOT_CYCLES apart.

REQ-012 Once a frame is granted it SHALL run to completion regardless of req or sched_en changes.

REQ-013 sched_en=0 SHALL only block new grants.

REQ-014 enc_en SHALL be a register that is 0 in reset and 1 from the first cycle after reset release; it SHALL never drop mid-frame.

REQ-015 busy SHALL be 1 in DATA and FLUSH.

REQ-016 Simultaneous requests SHALL produce exactly one grant per slot.

REQ-017 A requester's held req SHALL be served again only after all other active requesters have been served.

Reset
REQ-018 When rst=1 at a clock edge, the block SHALL enter IDLE with cnt=0 and RR pointer=0.

REQ-019 In reset, outputs SHALL be: rd=0, busy=0, owner=0, enc_en=0, enc_frame_start=0, enc_din=0.

REQ-020 Reset mid-frame SHALL abort the frame with no further rd pulses, and the dropped enc_en SHALL flush the encoder.

Configuration
REQ-021 With RS_SCHED_STATS_EN defined, the block SHALL add output frame_cnt (16*NREQ bits), one 16-bit counter per requester.
- A counter increments in the cycle of that requester's DATA cnt=MSG_WORDS-1.
- Counters wrap 65535->0 and clear on rst.

REQ-022 Without RS_SCHED_STATS_EN, the frame_cnt port and its counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-023 Package rs_enc_pkg SHALL hold:
- the state enum type;
- the MSG_WORDS and SLOT_CYCLES default constants;
- the encoder word width of 32.

REQ-024 Round-robin selection SHALL be a sub-module, rr_arbiter, with inputs req and last-grant pointer and outputs a one-hot grant plus index.

Verification
REQ-025 Single request: rst released, req=0001 at cycle 10 -> rd[0] high for cycles 10..69; enc_frame_start=1 at cycle 11 only; busy low at cycle 76.

REQ-026 Data path: requester 2 drives word k=0xA5000000+k -> enc_din equals those values on the 60 cycles after enc_frame_start is asserted, and is 0 otherwise.

REQ-027 All four requesters held high -> grant order 0,1,2,3,0; enc_frame_start pulses exactly 66 cycles apart; rd is never multi-hot.

REQ-028 sched_en dropped at DATA cnt=30 -> the frame completes all 60 rd cycles, then the block stays IDLE; re-raising sched_en grants on the next cycle.

REQ-029 rst asserted at DATA cnt=20 -> the next cycle has rd=0, enc_en=0 and busy=0; after release, requester 0 wins first.

REQ-030 With RS_SCHED_STATS_EN: after 3 frames to requester 1 -> frame_cnt[31:16]=3; preloading to 65535 via forced state then one more frame -> 0.

Source files
------------

// File: rtl/rs_enc_pkg.sv
// Shared types and defaults for the round-robin RS encoder front-end scheduler.
package rs_enc_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_FLUSH} state_e;

  localparam int MSG_WORDS_DEF   = 60;
  localparam int SLOT_CYCLES_DEF = 66;
  localparam int ENC_W           = 32;
endpackage

// File: rtl/rs_enc_x4_sched_rr_arbiter.sv
// Round-robin picker: scans req upward (with wrap) from prio_ptr, returns first hit.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      prio_ptr,
  output logic [NREQ-1:0] gnt,
  output logic [2:0]      gnt_idx,
  output logic            gnt_vld
);
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(prio_ptr) + k) % NREQ;
      if (!gnt_vld && req[idx]) begin
        gnt_vld  = 1'b1;
        gnt_idx  = 3'(idx);
        gnt[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rs_enc_x4_sched.sv
// Frame scheduler feeding one RS encoder from NREQ requesters in fixed-length slots.
// Optional per-requester frame counters under RS_SCHED_STATS_EN.
module rs_enc_x4_sched
  import rs_enc_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int MSG_WORDS   = MSG_WORDS_DEF,
  parameter int SLOT_CYCLES = SLOT_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sched_en,
  input  logic [NREQ-1:0]       req,
  input  logic [ENC_W*NREQ-1:0] din,
  output logic [NREQ-1:0]       rd,
  output logic                  busy,
  output logic [2:0]            owner,
  output logic                  enc_en,
  output logic                  enc_frame_start,
  output logic [ENC_W-1:0]      enc_din
`ifdef RS_SCHED_STATS_EN
  ,
  output logic [16*NREQ-1:0]    frame_cnt
`endif
);
  localparam int CW = $clog2(SLOT_CYCLES);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       owner_q, owner_d;
  logic             enc_en_q, enc_en_d;
  logic             fs_q, fs_d;
  logic [ENC_W-1:0] enc_din_q, enc_din_d;

  logic [NREQ-1:0]  gnt;
  logic [2:0]       gnt_idx;
  logic             gnt_vld;
  logic             data_last, flush_last;
  logic [ENC_W-1:0] own_word;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req),
    .prio_ptr(ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign data_last  = (state_q == ST_DATA)  && (cnt_q == CW'(MSG_WORDS - 1));
  assign flush_last = (state_q == ST_FLUSH) && (cnt_q == CW'(SLOT_CYCLES - MSG_WORDS - 1));

  always_comb begin
    rd       = '0;
    own_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == 3'(i)) own_word = din[ENC_W*i +: ENC_W];
      rd[i] = (state_q == ST_DATA) && (owner_q == 3'(i));
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    enc_en_d  = 1'b1;
    fs_d      = 1'b0;
    enc_din_d = '0;
    case (state_q)
      ST_DATA: begin
        fs_d      = (cnt_q == '0);
        enc_din_d = own_word;
        if (data_last) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_FLUSH: begin
        if (flush_last) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // New grant from IDLE or straight out of the last flush cycle keeps slots back-to-back.
    if (sched_en && gnt_vld && (state_q == ST_IDLE || flush_last)) begin
      state_d = ST_DATA;
      cnt_d   = '0;
      owner_d = gnt_idx;
      ptr_d   = (gnt_idx == 3'(NREQ - 1)) ? 3'd0 : gnt_idx + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      owner_q   <= '0;
      enc_en_q  <= 1'b0;
      fs_q      <= 1'b0;
      enc_din_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      enc_en_q  <= enc_en_d;
      fs_q      <= fs_d;
      enc_din_q <= enc_din_d;
    end
  end

  assign busy            = (state_q != ST_IDLE);
  assign owner           = owner_q;
  assign enc_en          = enc_en_q;
  assign enc_frame_start = fs_q;
  assign enc_din         = enc_din_q;

`ifdef RS_SCHED_STATS_EN
  logic [NREQ-1:0][15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    for (int i = 0; i < NREQ; i++)
      if (data_last && owner_q == 3'(i)) frame_cnt_d[i] = frame_cnt_q[i] + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) frame_cnt_q <= '0;
    else     frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`endif
endmodule
